ysyx_22050039_ifu: RTL and testbench

//  Instruction fetch unit; the producer side of the decoder's inst / pc_wen / pc_wdata interface.

---
 rtl/ysyx_22050039_ifu_pkg.sv | 21 ++
 rtl/ysyx_22050039_pc_gen.sv | 46 ++++
 rtl/ysyx_22050039_ifu.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22050039_ifu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050039_ifu_pkg.sv
// ysyx_22050039 IFU shared types and constants.
// Misaligned-fetch trap is built in when IFU_MISALIGN_CHK_EN is defined.
package ysyx_22050039_ifu_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22050039_pc_gen.sv
// Architectural PC register with reset / redirect / +4 / hold mux.
// IFU_MISALIGN_CHK_EN exposes the next-PC value to the fetch FSM.
module ysyx_22050039_pc_gen #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            wen_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            adv_i,
`ifdef IFU_MISALIGN_CHK_EN
  output logic [XLEN-1:0] pc_next_o,
`endif
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect has priority over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (!rst_n_i) begin
      pc_d = RESET_PC;
    end else if (wen_i) begin
      pc_d = wdata_i;
    end else if (adv_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;
`ifdef IFU_MISALIGN_CHK_EN
  assign pc_next_o = pc_d;
`endif

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: one outstanding fetch, valid/ready to decoder.
// Define IFU_MISALIGN_CHK_EN to trap misaligned PCs as a nop with fetch_err.
module ysyx_22050039_ifu
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_wen,
  input  logic [XLEN-1:0]     pc_wdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [XLEN-1:0]     mem_req_addr,
  input  logic                mem_resp_valid,
  input  logic [INST_LEN-1:0] mem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  output logic                fetch_err
);

  ifu_state_e state_q, state_d;
  logic squash_q, squash_d;
  logic req_valid_q, req_valid_d;
  logic inst_valid_q, inst_valid_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] pc_q;
  logic fire_req;
  logic fire_inst;
  logic adv;

  assign fire_req  = req_valid_q & mem_req_ready;
  assign fire_inst = inst_valid_q & inst_ready;
  assign adv = (state_q == IFU_HOLD) & fire_inst;

`ifdef IFU_MISALIGN_CHK_EN
  logic [XLEN-1:0] pc_d;
  logic fetch_err_q, fetch_err_d;
`endif

  ysyx_22050039_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk_i     (clk),
    .rst_n_i   (rst),
    .wen_i     (pc_wen),
    .wdata_i   (pc_wdata),
    .adv_i     (adv),
`ifdef IFU_MISALIGN_CHK_EN
    .pc_next_o (pc_d),
`endif
    .pc_o      (pc_q)
  );

  always_comb begin
    state_d      = state_q;
    squash_d     = squash_q;
    req_valid_d  = 1'b0;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
`ifdef IFU_MISALIGN_CHK_EN
    fetch_err_d  = fetch_err_q;
`endif
    unique case (state_q)
      IFU_IDLE: begin
        state_d     = IFU_REQ;
        req_valid_d = 1'b1;
      end
      IFU_REQ: begin
        if (fire_req) begin
          state_d  = IFU_WAIT;
          squash_d = pc_wen;
        end else begin
          // A redirect withdraws the request for one cycle.
          req_valid_d = !pc_wen;
        end
      end
      IFU_WAIT: begin
        if (mem_resp_valid) begin
          if (squash_q || pc_wen) begin
            squash_d    = 1'b0;
            state_d     = IFU_REQ;
            req_valid_d = 1'b1;
          end else begin
            inst_d       = mem_resp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = IFU_HOLD;
          end
        end else if (pc_wen) begin
          squash_d = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (pc_wen || fire_inst) begin
          inst_valid_d = 1'b0;
          state_d      = IFU_REQ;
          req_valid_d  = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
          fetch_err_d  = 1'b0;
`endif
        end
      end
    endcase
`ifdef IFU_MISALIGN_CHK_EN
    // Never issue a misaligned address; hand the decoder a flagged nop.
    if (req_valid_d && misaligned(pc_d[1:0])) begin
      req_valid_d  = 1'b0;
      state_d      = IFU_HOLD;
      inst_d       = INST_LEN'(NOP_INST);
      inst_pc_d    = pc_d;
      inst_valid_d = 1'b1;
      fetch_err_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IFU_IDLE;
      squash_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      squash_q     <= squash_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= fetch_err_d;
    end
  end
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Scoreboard bench for ysyx_22050039_ifu (request and instruction queues).
// Define IFU_MISALIGN_CHK_EN to exercise the misaligned-fetch trap.
module tb_ysyx_22050039_ifu;

  logic        clk;
  logic        rst;
  logic        pc_wen;
  logic [63:0] pc_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fetch_err;

  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
    logic        err;
  } exp_t;

  logic [63:0] exp_addr[$];
  exp_t        exp_inst[$];
  int n_pass = 0;
  int n_tot  = 0;
  int resp_delay = 1;

  ysyx_22050039_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .pc_wen         (pc_wen),
    .pc_wdata       (pc_wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bad(input string name);
    n_tot++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  function automatic logic [31:0] memword(input logic [63:0] a);
    return 32'h0000_0413 + {a[15:0], 16'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: one response resp_delay cycles after each accepted request.
  initial begin
    int cnt = 0;
    logic pend = 1'b0;
    logic [63:0] paddr = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = memword(paddr);
          pend = 1'b0;
        end
      end
      @(negedge clk);
      if (rst && mem_req_valid && mem_req_ready) begin
        pend  = 1'b1;
        cnt   = resp_delay;
        paddr = mem_req_addr;
      end
    end
  end

  // Monitor: handshakes seen at negedge complete at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && mem_req_valid && mem_req_ready) begin
        if (exp_addr.size() == 0) bad("req_unexpected");
        else chk("req_addr", mem_req_addr, exp_addr.pop_front());
      end
      if (rst && inst_valid && inst_ready) begin
        if (exp_inst.size() == 0) begin
          bad("inst_unexpected");
        end else begin
          exp_t e;
          e = exp_inst.pop_front();
          chk("inst", {32'h0, inst}, {32'h0, e.w});
          chk("inst_pc", inst_pc, e.pc);
          chk("fetch_err", {63'h0, fetch_err}, {63'h0, e.err});
        end
      end
    end
  end

  task automatic wait_inst_valid();
    int n = 0;
    while (!inst_valid && n < 20) begin
      tick();
      n++;
    end
    if (!inst_valid) bad("inst_valid_timeout");
  endtask

  task automatic accept_req();
    int n = 0;
    mem_req_ready = 1'b1;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!mem_req_valid) bad("req_timeout");
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic take_inst();
    inst_ready = 1'b1;
    wait_inst_valid();
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_inst.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (exp_inst.size() != 0) bad("drain_timeout");
  endtask

  initial begin
    rst = 1'b0;
    pc_wen = 1'b0;
    pc_wdata = '0;
    mem_req_ready = 1'b0;
    inst_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_addr", mem_req_addr, 64'h8000_0000);
    chk("rst_inst", {32'h0, inst}, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_fetch_err", {63'h0, fetch_err}, 64'h0);

    // 1: first fetch and latency
    rst = 1'b1;
    tick();
    chk("t1_req_valid", {63'h0, mem_req_valid}, 64'h1);
    chk("t1_addr", mem_req_addr, 64'h8000_0000);
    exp_addr.push_back(64'h8000_0000);
    exp_inst.push_back('{32'h0000_0413, 64'h8000_0000, 1'b0});
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("t1_valid_n1", {63'h0, inst_valid}, 64'h0);
    tick();
    chk("t1_valid_n2", {63'h0, inst_valid}, 64'h1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t1_next_valid", {63'h0, mem_req_valid}, 64'h1);
    chk("t1_next_addr", mem_req_addr, 64'h8000_0004);

    // 2: decoder stalls in HOLD
    exp_addr.push_back(64'h8000_0004);
    accept_req();
    wait_inst_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t2_inst", {32'h0, inst}, 64'h0004_0413);
      chk("t2_inst_pc", inst_pc, 64'h8000_0004);
      chk("t2_valid", {63'h0, inst_valid}, 64'h1);
      chk("t2_no_req", {63'h0, mem_req_valid}, 64'h0);
      tick();
    end
    exp_inst.push_back('{32'h0004_0413, 64'h8000_0004, 1'b0});
    take_inst();

    // 3: redirect while waiting, stale word squashed
    resp_delay = 3;
    exp_addr.push_back(64'h8000_0008);
    accept_req();
    inst_ready = 1'b1;
    pc_wen = 1'b1;
    pc_wdata = 64'h8000_0100;
    tick();
    pc_wen = 1'b0;
    chk("t3_addr", mem_req_addr, 64'h8000_0100);
    chk("t3_req_valid", {63'h0, mem_req_valid}, 64'h0);
    exp_addr.push_back(64'h8000_0100);
    exp_inst.push_back('{32'h0100_0413, 64'h8000_0100, 1'b0});
    accept_req();
    wait_drain();
    inst_ready = 1'b0;

    // 4: redirect in HOLD with simultaneous handshake
    resp_delay = 1;
    exp_addr.push_back(64'h8000_0104);
    accept_req();
    wait_inst_valid();
    exp_inst.push_back('{32'h0104_0413, 64'h8000_0104, 1'b0});
    inst_ready = 1'b1;
    pc_wen = 1'b1;
    pc_wdata = 64'h8000_0200;
    tick();
    inst_ready = 1'b0;
    pc_wen = 1'b0;
    chk("t4_req_valid", {63'h0, mem_req_valid}, 64'h1);
    chk("t4_addr", mem_req_addr, 64'h8000_0200);
    chk("t4_inst_valid", {63'h0, inst_valid}, 64'h0);
    exp_addr.push_back(64'h8000_0200);
    exp_inst.push_back('{32'h0200_0413, 64'h8000_0200, 1'b0});
    accept_req();
    take_inst();

    // 5: reset in WAIT, stale response lands in IDLE
    resp_delay = 2;
    exp_addr.push_back(64'h8000_0204);
    accept_req();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t5_req_valid", {63'h0, mem_req_valid}, 64'h0);
    chk("t5_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("t5_rst_addr", mem_req_addr, 64'h8000_0000);
    tick();
    chk("t5_idle_ignore", {63'h0, inst_valid}, 64'h0);
    chk("t5_req_up", {63'h0, mem_req_valid}, 64'h1);
    chk("t5_addr", mem_req_addr, 64'h8000_0000);
    resp_delay = 1;
    exp_addr.push_back(64'h8000_0000);
    exp_inst.push_back('{32'h0000_0413, 64'h8000_0000, 1'b0});
    accept_req();
    take_inst();

    // 6: redirect to a misaligned target
    pc_wen = 1'b1;
    pc_wdata = 64'h8000_0102;
    tick();
    pc_wen = 1'b0;
    chk("t6_drop", {63'h0, mem_req_valid}, 64'h0);
`ifdef IFU_MISALIGN_CHK_EN
    mem_req_ready = 1'b1;
    exp_inst.push_back('{32'h0000_0013, 64'h8000_0102, 1'b1});
    wait_inst_valid();
    chk("t6_err", {63'h0, fetch_err}, 64'h1);
    chk("t6_no_req", {63'h0, mem_req_valid}, 64'h0);
    take_inst();
    exp_inst.push_back('{32'h0000_0013, 64'h8000_0106, 1'b1});
    take_inst();
    mem_req_ready = 1'b0;
`else
    tick();
    chk("t6_reraise", {63'h0, mem_req_valid}, 64'h1);
    chk("t6_addr", mem_req_addr, 64'h8000_0102);
    exp_addr.push_back(64'h8000_0102);
    exp_inst.push_back('{32'h0102_0413, 64'h8000_0102, 1'b0});
    accept_req();
    take_inst();
`endif

    repeat (3) tick();
    chk("addr_q_empty", 64'(exp_addr.size()), 64'h0);
    chk("inst_q_empty", 64'(exp_inst.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
